// File: rtl/video_pkg.sv
// Video constants shared by the binarizer/packer and unpacker paths.
package video_pkg;

    localparam int unsigned DATA_W_DEF   = 24;
    localparam logic [23:0] FG_COLOR_DEF = 24'hFFFFFF;
    localparam logic [23:0] BG_COLOR_DEF = 24'h000000;

    // Bit counter must hold the full word size, hence one bit above log2.
    function automatic int unsigned cnt_width(input int unsigned word_w);
        return $clog2(word_w) + 1;
    endfunction

endpackage

// File: rtl/mono_unpack.sv
// Replays packed 1-bit pixels from a show-ahead FIFO against vsync/href/de timing,
// expanding each bit to a foreground/background colour one clock later.
module mono_unpack
    import video_pkg::*;
#(
    parameter int unsigned       WORD_W    = 32,
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] FG_COLOR  = DATA_W'(FG_COLOR_DEF),
    parameter logic [DATA_W-1:0] BG_COLOR  = DATA_W'(BG_COLOR_DEF),
    parameter bit                MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic              de,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              post_vsync,
    output logic              post_href,
    output logic              post_de,
    output logic [DATA_W-1:0] post_data,
    output logic              underflow,
    output logic [15:0]       uf_count
);

    localparam int unsigned CNT_W = cnt_width(WORD_W);

    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_vsync_d;
    logic              r_de_d;

    logic              w_frame_start;
    logic              w_line_end;
    logic [CNT_W-1:0]  w_cnt_eff;
    logic              w_need_word;
    logic              w_starve;
    logic              w_pixel;
    logic [WORD_W-1:0] w_shreg_nxt;
    logic [15:0]       w_uf_base;

    always_comb begin
        w_frame_start = vsync & ~r_vsync_d;
        w_line_end    = r_de_d & ~de;
        // A frame start discards stale bits in the same cycle it is seen.
        w_cnt_eff     = w_frame_start ? '0 : r_cnt;
        w_need_word   = de && (w_cnt_eff == '0);
        fifo_rd       = w_need_word & ~fifo_empty & rst_n;
        w_starve      = w_need_word & fifo_empty;
        w_pixel       = 1'b0;
        w_shreg_nxt   = r_shreg;
        if (fifo_rd) begin
            w_pixel     = MSB_FIRST ? fifo_rdata[WORD_W-1] : fifo_rdata[0];
            w_shreg_nxt = MSB_FIRST ? (fifo_rdata << 1) : (fifo_rdata >> 1);
        end else if (de && (w_cnt_eff != '0)) begin
            w_pixel     = MSB_FIRST ? r_shreg[WORD_W-1] : r_shreg[0];
            w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
        end
        w_uf_base = w_frame_start ? '0 : uf_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_vsync_d  <= 1'b0;
            r_de_d     <= 1'b0;
            post_vsync <= 1'b0;
            post_href  <= 1'b0;
            post_de    <= 1'b0;
            post_data  <= '0;
            underflow  <= 1'b0;
            uf_count   <= '0;
        end else begin
            r_vsync_d  <= vsync;
            r_de_d     <= de;
            post_vsync <= vsync;
            post_href  <= href;
            post_de    <= de;
            post_data  <= (de && w_pixel) ? FG_COLOR : BG_COLOR;
            r_shreg    <= w_shreg_nxt;

            if (fifo_rd) begin
                r_cnt <= CNT_W'(WORD_W - 1);
            end else if (de && (w_cnt_eff != '0)) begin
                r_cnt <= w_cnt_eff - 1'b1;
            end else if (w_frame_start || w_line_end) begin
                r_cnt <= '0;
            end

            // A starved pixel on the frame-start cycle counts toward the new frame.
            underflow <= w_starve | (underflow & ~w_frame_start);
            uf_count  <= (w_starve && (w_uf_base != '1)) ? w_uf_base + 16'd1 : w_uf_base;
        end
    end

endmodule

// File: tb/tb_mono_unpack.sv
// Randomized and directed bench for mono_unpack; a bit-queue model predicts pops and pixels.
module tb_mono_unpack;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        de = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rdata = '0;

    logic        fifo_rd, post_vsync, post_href, post_de, underflow;
    logic [23:0] post_data;
    logic [15:0] uf_count;
    logic        m_fifo_rd, m_post_vsync, m_post_href, m_post_de, m_underflow;
    logic [23:0] m_post_data;
    logic [15:0] m_uf_count;

    always #5 clk = ~clk;

    mono_unpack #(.WORD_W(32), .DATA_W(24), .FG_COLOR(FG), .BG_COLOR(BG), .MSB_FIRST(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .de(de),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
        .post_vsync(post_vsync), .post_href(post_href), .post_de(post_de),
        .post_data(post_data), .underflow(underflow), .uf_count(uf_count)
    );

    mono_unpack #(.WORD_W(32), .DATA_W(24), .FG_COLOR(FG), .BG_COLOR(BG), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .de(de),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(m_fifo_rd),
        .post_vsync(m_post_vsync), .post_href(m_post_href), .post_de(m_post_de),
        .post_data(m_post_data), .underflow(m_underflow), .uf_count(m_uf_count)
    );

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned pops = 0;

    logic [31:0] q[$];
    bit          bits_l[$];
    bit          bits_m[$];
    bit          m_vs_d = 1'b0;
    bit          m_de_d = 1'b0;
    bit          m_uf = 1'b0;
    logic [15:0] m_ufc = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits_l.delete();
        bits_m.delete();
        m_vs_d = 1'b0;
        m_de_d = 1'b0;
        m_uf   = 1'b0;
        m_ufc  = '0;
    endtask

    task automatic step(input bit v, input bit h, input bit d, input bit starve);
        logic [31:0] w;
        bit exp_rd, pl, pm;
        @(negedge clk);
        vsync      = v;
        href       = h;
        de         = d;
        fifo_empty = starve || (q.size() == 0);
        fifo_rdata = fifo_empty ? $urandom : q[0];
        if ((v && !m_vs_d) || (m_de_d && !d)) begin
            bits_l.delete();
            bits_m.delete();
        end
        if (v && !m_vs_d) begin
            m_uf  = 1'b0;
            m_ufc = '0;
        end
        exp_rd = 1'b0;
        pl = 1'b0;
        pm = 1'b0;
        if (d) begin
            if (bits_l.size() == 0) begin
                if (!fifo_empty) begin
                    w = q.pop_front();
                    exp_rd = 1'b1;
                    for (int i = 0; i < 32; i++) begin
                        bits_l.push_back(w[i]);
                        bits_m.push_back(w[31-i]);
                    end
                end else begin
                    m_uf = 1'b1;
                    if (m_ufc != 16'hFFFF) m_ufc++;
                end
            end
            if (bits_l.size() != 0) begin
                pl = bits_l.pop_front();
                pm = bits_m.pop_front();
            end
        end
        #1;
        check_eq("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
        check_eq("fifo_rd_msb", 32'(m_fifo_rd), 32'(exp_rd));
        if (fifo_rd) pops++;
        @(posedge clk);
        #1;
        check_eq("post_vsync", 32'(post_vsync), 32'(v));
        check_eq("post_href", 32'(post_href), 32'(h));
        check_eq("post_de", 32'(post_de), 32'(d));
        check_eq("post_data", 32'(post_data), 32'(pl ? FG : BG));
        check_eq("post_data_msb", 32'(m_post_data), 32'(pm ? FG : BG));
        check_eq("underflow", 32'(underflow), 32'(m_uf));
        check_eq("uf_count", 32'(uf_count), 32'(m_ufc));
        m_vs_d = v;
        m_de_d = d;
    endtask

    task automatic frame_start();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic line(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"}, 32'(fifo_rd | m_fifo_rd), 32'd0);
        check_eq({tag, "_post"}, 32'({post_vsync, post_href, post_de, underflow}), 32'd0);
        check_eq({tag, "_data"}, 32'(post_data), 32'd0);
        check_eq({tag, "_ufc"}, 32'(uf_count), 32'd0);
    endtask

    initial begin
        int unsigned n;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two words over one 64-pixel line
        q.push_back(32'h0000_00FF);
        q.push_back(32'h8000_0001);
        frame_start();
        pops = 0;
        line(64);
        check_eq("t1_pops", pops, 32'd2);

        // 40-pixel line discards the tail of word 2
        q.push_back($urandom);
        q.push_back($urandom);
        q.push_back($urandom);
        pops = 0;
        line(40);
        line(16);
        check_eq("t2_pops", pops, 32'd3);

        // Starved FIFO mid-line
        q.push_back($urandom);
        q.push_back($urandom);
        for (int i = 0; i < 32; i++) step(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
        for (int i = 0; i < 32; i++) step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        check_eq("t3_uf", 32'(underflow), 32'd1);
        check_eq("t3_ufc", 32'(uf_count), 32'd3);
        frame_start();
        check_eq("t3_uf_clr", 32'(underflow), 32'd0);
        check_eq("t3_ufc_clr", 32'(uf_count), 32'd0);

        // Single set MSB, seen first by the MSB-first instance
        q.push_back(32'h8000_0000);
        line(32);

        // vsync rises with 5 bits left and de high
        q.push_back($urandom);
        q.push_back($urandom);
        for (int i = 0; i < 27; i++) step(0, 1, 1, 0);
        pops = 0;
        step(1, 1, 1, 0);
        check_eq("t5_pop", pops, 32'd1);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Reset asserted mid-line
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back($urandom);
        frame_start();
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
        @(negedge clk);
        de = 1'b1;
        href = 1'b1;
        fifo_empty = 1'b0;
        fifo_rdata = q[0];
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        de = 1'b0;
        href = 1'b0;
        vsync = 1'b0;
        rst_n = 1'b1;
        q.delete();
        model_reset();
        q.push_back(32'hA5A5_0F0F);
        frame_start();
        line(32);

        // Random frames with occasional starvation
        for (int f = 0; f < 4; f++) begin
            frame_start();
            for (int l = 0; l < 3; l++) begin
                n = $urandom_range(80, 8);
                for (int unsigned k = 0; k < (n + 31) / 32 + $urandom_range(1, 0); k++)
                    q.push_back($urandom);
                for (int unsigned i = 0; i < n; i++)
                    step(0, 1, 1, ($urandom_range(15, 0) == 0));
                for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
